// File: rtl/led_alarm_sequencer_if.sv
// ---------------------------------------------------------------------------
// led_alarm_sequencer_if
//   Bundles the LED pattern path and the alarm control/status signals of the
//   LED alarm sequencer so that producer and consumer share one port.
//
//   Signals:
//     leds      normal-mode LED pattern from the pattern generator
//     explosion level, 1 = trigger the alarm sequence
//     clear     level, returns the sequencer to pass-through
//     now       registered LED drive towards the board LEDs
//     busy      1 while the alarm sequence or hold is active
//
//   Modports:
//     master  drives leds/explosion/clear, observes now/busy
//     slave   the sequencer itself
// ---------------------------------------------------------------------------
interface led_alarm_sequencer_if #(
    parameter int N_LEDS = 7
);
    logic [N_LEDS-1:0] leds;
    logic              explosion;
    logic              clear;
    logic [N_LEDS-1:0] now;
    logic              busy;

    modport master (
        output leds,
        output explosion,
        output clear,
        input  now,
        input  busy
    );

    modport slave (
        input  leds,
        input  explosion,
        input  clear,
        output now,
        output busy
    );
endinterface

// File: rtl/led_alarm_sequencer.sv
// ---------------------------------------------------------------------------
// led_alarm_sequencer
//   Registered LED alarm override. In pass-through the game's LED pattern is
//   forwarded to the board LEDs with one clock of latency. An explosion
//   starts a timed blink sequence on all channels, after which every LED is
//   latched on until clear is asserted while explosion is low.
//
//   Ports:
//     clk    system clock, rising edge
//     reset  asynchronous, active-high reset
//     bus    led_alarm_sequencer_if.slave
//              leds (in), explosion (in), clear (in), now (out), busy (out)
//
//   Parameters:
//     N_LEDS     number of LED channels (>= 1)
//     BLINK_DIV  clock cycles per blink half-period (>= 1)
//     N_BLINKS   full on/off blink cycles before latching on (>= 1)
//
//   Build option:
//     LED_ALT_PATTERN_EN  when defined, blink phases alternate between the
//                         even-index and odd-index channel masks instead of
//                         all on / all off. The hold pattern stays all on.
// ---------------------------------------------------------------------------
module led_alarm_sequencer #(
    parameter int N_LEDS    = 7,
    parameter int BLINK_DIV = 25000000,
    parameter int N_BLINKS  = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    led_alarm_sequencer_if.slave bus
);

    localparam int DIV_W  = (BLINK_DIV > 1)    ? $clog2(BLINK_DIV)    : 1;
    localparam int HALF_W = (2 * N_BLINKS > 1) ? $clog2(2 * N_BLINKS) : 1;

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(BLINK_DIV - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(2 * N_BLINKS - 1);

    localparam logic [N_LEDS-1:0] ALL_ONES = {N_LEDS{1'b1}};

    localparam logic [1:0] ST_PASS  = 2'd0;
    localparam logic [1:0] ST_FLASH = 2'd1;
    localparam logic [1:0] ST_HOLD  = 2'd2;

`ifdef LED_ALT_PATTERN_EN
    // Channels 0,2,4,... set; used for the "on" phase, its complement for "off".
    function automatic logic [N_LEDS-1:0] evenMask();
        logic [N_LEDS-1:0] m;
        for (int i = 0; i < N_LEDS; i++) begin
            m[i] = ((i % 2) == 0);
        end
        return m;
    endfunction

    localparam logic [N_LEDS-1:0] ON_PAT  = evenMask();
    localparam logic [N_LEDS-1:0] OFF_PAT = ~ON_PAT;
`else
    localparam logic [N_LEDS-1:0] ON_PAT  = ALL_ONES;
    localparam logic [N_LEDS-1:0] OFF_PAT = '0;
`endif

    logic [1:0]        state_q, state_d;
    logic [DIV_W-1:0]  div_q,   div_d;
    logic [HALF_W-1:0] half_q,  half_d;
    logic              phase_q, phase_d;
    logic [N_LEDS-1:0] now_q,   now_d;
    logic              busy_q,  busy_d;

    // Next-state logic. A qualified clear (clear high, explosion low) is
    // checked before the blink timing so that it wins even on a half-period
    // boundary. Explosion is only looked at in PASS, so holding or
    // re-asserting it during FLASH/HOLD never restarts the sequence.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        half_d  = half_q;
        phase_d = phase_q;
        now_d   = now_q;
        busy_d  = busy_q;

        case (state_q)
            ST_PASS: begin
                now_d  = bus.leds;
                busy_d = 1'b0;
                if (bus.explosion) begin
                    state_d = ST_FLASH;
                    now_d   = ON_PAT;
                    busy_d  = 1'b1;
                    div_d   = '0;
                    half_d  = '0;
                    phase_d = 1'b1;
                end
            end

            ST_FLASH: begin
                busy_d = 1'b1;
                if (bus.clear && !bus.explosion) begin
                    state_d = ST_PASS;
                    now_d   = bus.leds;
                    busy_d  = 1'b0;
                    div_d   = '0;
                    half_d  = '0;
                    phase_d = 1'b0;
                end else if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (half_q == HALF_LAST) begin
                        state_d = ST_HOLD;
                        now_d   = ALL_ONES;
                    end else begin
                        half_d  = half_q + 1'b1;
                        phase_d = ~phase_q;
                        // The pattern shown is that of the phase being entered.
                        now_d   = phase_q ? OFF_PAT : ON_PAT;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end

            ST_HOLD: begin
                now_d  = ALL_ONES;
                busy_d = 1'b1;
                if (bus.clear && !bus.explosion) begin
                    state_d = ST_PASS;
                    now_d   = bus.leds;
                    busy_d  = 1'b0;
                    div_d   = '0;
                    half_d  = '0;
                    phase_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_PASS;
                now_d   = '0;
                busy_d  = 1'b0;
                div_d   = '0;
                half_d  = '0;
                phase_d = 1'b0;
            end
        endcase
    end

    // State, counters and the registered outputs; reset clears everything
    // immediately so the LEDs go dark without waiting for a clock.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_PASS;
            div_q   <= '0;
            half_q  <= '0;
            phase_q <= 1'b0;
            now_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            half_q  <= half_d;
            phase_q <= phase_d;
            now_q   <= now_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.now  = now_q;
    assign bus.busy = busy_q;

endmodule
